stage_memory: RTL and testbench

Memory stage of the five-stage MIPS pipeline. It consumes the execute-stage results held in the EX/MEM register (ALU result, store data, destination register, zero flag, branch target) and resolves the branch decision combinationally. It performs word loads and stores against an internal data RAM and registers the outcome into the MEM/WB pipeline register that feeds write-back. It also supports pipeline stall/flush and flags bad data addresses.

---
 rtl/stage_memory.sv | 93 +++++++++
 tb/tb_stage_memory.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_memory.sv
// MIPS MEM stage: word RAM plus MEM/WB register; branch decision is combinational, MEM/WB has one-cycle latency.
// STALL freezes MEM/WB and blocks stores; FLUSH loads a bubble; STALL wins when both are high.
module stage_memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             REGWRITE,
  input  logic             MEMTOREG,
  input  logic             MEMWRITE,
  input  logic             MEMREAD,
  input  logic             BRANCH,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] writedata,
  input  logic [4:0]       writereg,
  input  logic             zero,
  input  logic [WIDTH-1:0] pcbranch,
  output logic             PCSRC,
  output logic [WIDTH-1:0] pcbranch_m,
  output logic             REGWRITE_W,
  output logic             MEMTOREG_W,
  output logic [WIDTH-1:0] readdata_W,
  output logic [WIDTH-1:0] aluresult_W,
  output logic [4:0]       writereg_W,
  output logic             memerror
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    index;
  logic             access;
  logic             bad;
  logic             advance;
  logic             store_en;
  logic [WIDTH-1:0] readdata;

  always_comb begin
    index    = aluresult[AW+1:2];
    access   = MEMREAD | MEMWRITE;
    bad      = access && ((aluresult[1:0] != 2'b00) || (aluresult[WIDTH-1:AW+2] != '0));
    advance  = !STALL && !FLUSH;
    store_en = MEMWRITE && advance && !bad;
    // Non-loads and bad loads capture zero so write-back never sees stale RAM data.
    readdata = (MEMREAD && !bad) ? ram[index] : '0;
  end

  assign PCSRC      = BRANCH & zero & ~FLUSH;
  assign pcbranch_m = pcbranch;

  // RAM contents survive reset; reset only blocks a store on an edge where it is low.
  always_ff @(posedge clk or negedge reset) begin
    if (reset && store_en) begin
      ram[index] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      REGWRITE_W  <= 1'b0;
      MEMTOREG_W  <= 1'b0;
      readdata_W  <= '0;
      aluresult_W <= '0;
      writereg_W  <= '0;
    end else if (!STALL) begin
      if (FLUSH) begin
        REGWRITE_W  <= 1'b0;
        MEMTOREG_W  <= 1'b0;
        readdata_W  <= '0;
        aluresult_W <= '0;
        writereg_W  <= '0;
      end else begin
        REGWRITE_W  <= REGWRITE & ~bad;
        MEMTOREG_W  <= MEMTOREG;
        readdata_W  <= readdata;
        aluresult_W <= aluresult;
        writereg_W  <= writereg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memerror <= 1'b0;
    end else if (bad && advance) begin
      memerror <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: vector table plus directed reset, stall and back-to-back sequences.
module tb_stage_memory;

  localparam logic [6:0] C_SW  = 7'b0010000;
  localparam logic [6:0] C_LW  = 7'b1101000;
  localparam logic [6:0] C_LWX = 7'b0001000;
  localparam logic [6:0] C_BEQ = 7'b0000100;
  localparam logic [6:0] C_ADD = 7'b1000000;
  localparam logic [6:0] C_ST  = 7'b0000010;
  localparam logic [6:0] C_FL  = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        REGWRITE = 1'b0, MEMTOREG = 1'b0, MEMWRITE = 1'b0, MEMREAD = 1'b0;
  logic        BRANCH = 1'b0, STALL = 1'b0, FLUSH = 1'b0, zero = 1'b0;
  logic [31:0] aluresult = '0, writedata = '0, pcbranch = '0;
  logic [4:0]  writereg = '0;
  logic        PCSRC, REGWRITE_W, MEMTOREG_W, memerror;
  logic [31:0] pcbranch_m, readdata_W, aluresult_W;
  logic [4:0]  writereg_W;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string       name;
    logic [6:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        z;
    logic        e_pcsrc;
    logic        e_rw;
    logic        e_mtr;
    logic        chk_rd;
    logic [31:0] e_rd;
    logic [31:0] e_alu;
    logic [4:0]  e_wr;
    logic        e_merr;
  } vec_t;

  typedef struct {
    string       name;
    logic        rw;
    logic        mtr;
    logic        chk_rd;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        merr;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[18];

  stage_memory #(.WIDTH(32), .DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .REGWRITE(REGWRITE), .MEMTOREG(MEMTOREG), .MEMWRITE(MEMWRITE), .MEMREAD(MEMREAD),
    .BRANCH(BRANCH), .STALL(STALL), .FLUSH(FLUSH),
    .aluresult(aluresult), .writedata(writedata), .writereg(writereg),
    .zero(zero), .pcbranch(pcbranch),
    .PCSRC(PCSRC), .pcbranch_m(pcbranch_m),
    .REGWRITE_W(REGWRITE_W), .MEMTOREG_W(MEMTOREG_W), .readdata_W(readdata_W),
    .aluresult_W(aluresult_W), .writereg_W(writereg_W), .memerror(memerror)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  function automatic vec_t mk(input string n, input logic [6:0] c, input logic [31:0] alu,
                              input logic [31:0] wd, input logic [4:0] wr, input logic z,
                              input logic e_pcsrc, input logic e_rw, input logic e_mtr,
                              input logic chk_rd, input logic [31:0] e_rd,
                              input logic [31:0] e_alu, input logic [4:0] e_wr,
                              input logic e_merr);
    vec_t v;
    v.name = n; v.ctrl = c; v.alu = alu; v.wd = wd; v.wr = wr; v.z = z;
    v.e_pcsrc = e_pcsrc; v.e_rw = e_rw; v.e_mtr = e_mtr; v.chk_rd = chk_rd;
    v.e_rd = e_rd; v.e_alu = e_alu; v.e_wr = e_wr; v.e_merr = e_merr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {REGWRITE, MEMTOREG, MEMWRITE, MEMREAD, BRANCH, STALL, FLUSH} = v.ctrl;
    aluresult = v.alu;
    writedata = v.wd;
    writereg  = v.wr;
    zero      = v.z;
    pcbranch  = 32'h0000_0040;
  endtask

  task automatic check_wb(input exp_t e);
    chk({e.name, ".regwrite_w"}, 32'(REGWRITE_W), 32'(e.rw));
    chk({e.name, ".memtoreg_w"}, 32'(MEMTOREG_W), 32'(e.mtr));
    if (e.chk_rd) chk({e.name, ".readdata_w"}, readdata_W, e.rd);
    chk({e.name, ".aluresult_w"}, aluresult_W, e.alu);
    chk({e.name, ".writereg_w"}, 32'(writereg_W), 32'(e.wr));
    chk({e.name, ".memerror"}, 32'(memerror), 32'(e.merr));
  endtask

  // Drive one instruction a cycle, check the combinational branch outputs, then the MEM/WB result.
  task automatic apply(input vec_t v);
    exp_t e;
    drive(v);
    #1;
    chk({v.name, ".pcsrc"}, 32'(PCSRC), 32'(v.e_pcsrc));
    chk({v.name, ".pcbranch_m"}, pcbranch_m, 32'h0000_0040);
    e.name = v.name; e.rw = v.e_rw; e.mtr = v.e_mtr; e.chk_rd = v.chk_rd;
    e.rd = v.e_rd; e.alu = v.e_alu; e.wr = v.e_wr; e.merr = v.e_merr;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_wb(sbq.pop_front());
  endtask

  task automatic check_all_zero(input string name);
    chk({name, ".pcsrc"}, 32'(PCSRC), 32'd0);
    chk({name, ".regwrite_w"}, 32'(REGWRITE_W), 32'd0);
    chk({name, ".memtoreg_w"}, 32'(MEMTOREG_W), 32'd0);
    chk({name, ".readdata_w"}, readdata_W, 32'd0);
    chk({name, ".aluresult_w"}, aluresult_W, 32'd0);
    chk({name, ".writereg_w"}, 32'(writereg_W), 32'd0);
    chk({name, ".memerror"}, 32'(memerror), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk("sw_00",       C_SW,             32'h00,  32'h1111_1111, 5'd0,  1'b0, 0, 0, 0, 0, 32'h0,         32'h00,  5'd0,  0);
    vecs[1]  = mk("sw_10",       C_SW,             32'h10,  32'hDEAD_BEEF, 5'd0,  1'b0, 0, 0, 0, 0, 32'h0,         32'h10,  5'd0,  0);
    vecs[2]  = mk("sw_20",       C_SW,             32'h20,  32'hCAFE_F00D, 5'd0,  1'b0, 0, 0, 0, 0, 32'h0,         32'h20,  5'd0,  0);
    vecs[3]  = mk("lw_10",       C_LW,             32'h10,  32'h0,         5'd8,  1'b0, 0, 1, 1, 1, 32'hDEAD_BEEF, 32'h10,  5'd8,  0);
    vecs[4]  = mk("beq_taken",   C_BEQ,            32'h00,  32'h0,         5'd0,  1'b1, 1, 0, 0, 0, 32'h0,         32'h00,  5'd0,  0);
    vecs[5]  = mk("beq_nottkn",  C_BEQ,            32'h04,  32'h0,         5'd0,  1'b0, 0, 0, 0, 0, 32'h0,         32'h04,  5'd0,  0);
    vecs[6]  = mk("beq_flush",   C_BEQ | C_FL,     32'h00,  32'h0,         5'd0,  1'b1, 0, 0, 0, 1, 32'h0,         32'h00,  5'd0,  0);
    vecs[7]  = mk("add_55",      C_ADD,            32'h55,  32'h0,         5'd3,  1'b0, 0, 1, 0, 0, 32'h0,         32'h55,  5'd3,  0);
    vecs[8]  = mk("sw_stall",    C_SW | C_ST,      32'h20,  32'h1234,      5'd0,  1'b0, 0, 1, 0, 0, 32'h0,         32'h55,  5'd3,  0);
    vecs[9]  = mk("sw_flush",    C_SW | C_FL,      32'h20,  32'h1234,      5'd0,  1'b0, 0, 0, 0, 1, 32'h0,         32'h00,  5'd0,  0);
    vecs[10] = mk("add_77",      C_ADD,            32'h77,  32'h0,         5'd5,  1'b0, 0, 1, 0, 0, 32'h0,         32'h77,  5'd5,  0);
    vecs[11] = mk("sw_stfl",     C_SW | C_ST | C_FL, 32'h20, 32'h1234,     5'd0,  1'b0, 0, 1, 0, 0, 32'h0,         32'h77,  5'd5,  0);
    vecs[12] = mk("lw_20",       C_LW,             32'h20,  32'h0,         5'd9,  1'b0, 0, 1, 1, 1, 32'hCAFE_F00D, 32'h20,  5'd9,  0);
    vecs[13] = mk("lw_nomtr",    C_LWX,            32'h10,  32'h0,         5'd11, 1'b0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'h10,  5'd11, 0);
    vecs[14] = mk("lw_misalign", C_LW,             32'h13,  32'h0,         5'd4,  1'b0, 0, 0, 1, 1, 32'h0,         32'h13,  5'd4,  1);
    vecs[15] = mk("lw_after_err", C_LW,            32'h10,  32'h0,         5'd6,  1'b0, 0, 1, 1, 1, 32'hDEAD_BEEF, 32'h10,  5'd6,  1);
    vecs[16] = mk("sw_range",    C_SW,             32'h100, 32'h0000_0BAD, 5'd0,  1'b0, 0, 0, 0, 0, 32'h0,         32'h100, 5'd0,  1);
    vecs[17] = mk("lw_00",       C_LW,             32'h00,  32'h0,         5'd12, 1'b0, 0, 1, 1, 1, 32'h1111_1111, 32'h00,  5'd12, 1);

    #12;
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset between edges, then a store on an edge while reset is low.
    apply(mk("add_aa", C_ADD, 32'hAA, 32'h0, 5'd2, 1'b0, 0, 1, 0, 0, 32'h0, 32'hAA, 5'd2, 1));
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    drive(mk("sw_in_reset", C_SW, 32'h10, 32'h9999_9999, 5'd0, 1'b0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(mk("lw_post_reset", C_LW, 32'h10, 32'h0, 5'd8, 1'b0, 0, 1, 1, 1, 32'hDEAD_BEEF, 32'h10, 5'd8, 0));

    // Three-cycle stall holds outputs and blocks the store; the released store lands once.
    apply(mk("sw_24_init", C_SW, 32'h24, 32'h0BAD_F00D, 5'd0, 1'b0, 0, 0, 0, 0, 32'h0, 32'h24, 5'd0, 0));
    apply(mk("add_5a", C_ADD, 32'h5A, 32'h0, 5'd7, 1'b0, 0, 1, 0, 0, 32'h0, 32'h5A, 5'd7, 0));
    for (int k = 0; k < 3; k++)
      apply(mk($sformatf("stall_%0d", k), C_SW | C_ST, 32'h24, 32'h77, 5'd0, 1'b0, 0, 1, 0, 0, 32'h0, 32'h5A, 5'd7, 0));
    apply(mk("lw_24_kept", C_LW, 32'h24, 32'h0, 5'd10, 1'b0, 0, 1, 1, 1, 32'h0BAD_F00D, 32'h24, 5'd10, 0));
    apply(mk("sw_24_go", C_SW, 32'h24, 32'h77, 5'd0, 1'b0, 0, 0, 0, 0, 32'h0, 32'h24, 5'd0, 0));
    apply(mk("lw_24_new", C_LW, 32'h24, 32'h0, 5'd10, 1'b0, 0, 1, 1, 1, 32'h77, 32'h24, 5'd10, 0));

    // Back-to-back stores then loads, one instruction per cycle.
    for (int i = 0; i < 8; i++)
      apply(mk($sformatf("b2b_sw_%0d", i), C_SW, 32'(i * 4), 32'hA000_0000 | (32'(i) * 32'h0101_0101),
               5'd0, 1'b0, 0, 0, 0, 0, 32'h0, 32'(i * 4), 5'd0, 0));
    for (int i = 0; i < 8; i++)
      apply(mk($sformatf("b2b_lw_%0d", i), C_LW, 32'(i * 4), 32'h0, 5'(i + 1), 1'b0, 0, 1, 1, 1,
               32'hA000_0000 | (32'(i) * 32'h0101_0101), 32'(i * 4), 5'(i + 1), 0));

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
